// File: rtl/mult_div_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mult_div_unit_pkg
// Description : Start/XAluOp encodings shared by the decoder and the HI/LO unit.
// Revision    : 1.0 - initial release
// ============================================================================
package mult_div_unit_pkg;

    localparam int START_SIZE  = 2;
    localparam int XALUOP_SIZE = 3;

    typedef logic [START_SIZE-1:0]  start_t;
    typedef logic [XALUOP_SIZE-1:0] xaluop_t;

    localparam start_t MD_NONE = 2'd0;
    localparam start_t MD_RUN  = 2'd1;
    localparam start_t MD_MOVE = 2'd2;

    localparam xaluop_t MD_MULT  = 3'd0;
    localparam xaluop_t MD_MULTU = 3'd1;
    localparam xaluop_t MD_DIV   = 3'd2;
    localparam xaluop_t MD_DIVU  = 3'd3;
    localparam xaluop_t MD_MTHI  = 3'd4;
    localparam xaluop_t MD_MTLO  = 3'd5;

endpackage
`default_nettype wire

// File: rtl/mult_div_unit_arith.sv
`default_nettype none
// ============================================================================
// Module      : md_arith
// Description : Combinational signed/unsigned 32x32 multiply and divide.
// Revision    : 1.0 - initial release
// ============================================================================
module md_arith
    import mult_div_unit_pkg::*;
(
    input  logic [31:0]            A,
    input  logic [31:0]            B,
    input  logic [XALUOP_SIZE-1:0] XAluOp,
    output logic [31:0]            res_hi,
    output logic [31:0]            res_lo,
    output logic                   div_zero
);

    logic        w_is_signed;
    logic        w_is_div;
    logic [63:0] w_ext_a;
    logic [63:0] w_ext_b;
    logic [63:0] w_prod;
    logic [31:0] w_mag_a;
    logic [31:0] w_mag_b;
    logic [31:0] w_divisor;
    logic [31:0] w_q_mag;
    logic [31:0] w_r_mag;
    logic [31:0] w_quot;
    logic [31:0] w_rem;

    assign w_is_signed = (XAluOp == MD_MULT) || (XAluOp == MD_DIV);
    assign w_is_div    = (XAluOp == MD_DIV)  || (XAluOp == MD_DIVU);

    // Sign-extending to 64 bits makes the low 64 product bits correct for both modes.
    assign w_ext_a = w_is_signed ? {{32{A[31]}}, A} : {32'd0, A};
    assign w_ext_b = w_is_signed ? {{32{B[31]}}, B} : {32'd0, B};
    assign w_prod  = w_ext_a * w_ext_b;

    // Divide on magnitudes, then restore signs; 0x80000000/-1 falls out as 0x80000000 rem 0.
    assign w_mag_a   = (w_is_signed && A[31]) ? (32'd0 - A) : A;
    assign w_mag_b   = (w_is_signed && B[31]) ? (32'd0 - B) : B;
    assign w_divisor = (B == 32'd0) ? 32'd1 : w_mag_b;
    assign w_q_mag   = w_mag_a / w_divisor;
    assign w_r_mag   = w_mag_a % w_divisor;
    assign w_quot    = (w_is_signed && (A[31] ^ B[31])) ? (32'd0 - w_q_mag) : w_q_mag;
    assign w_rem     = (w_is_signed && A[31]) ? (32'd0 - w_r_mag) : w_r_mag;

    assign div_zero = w_is_div && (B == 32'd0);
    assign res_hi   = w_is_div ? w_rem  : w_prod[63:32];
    assign res_lo   = w_is_div ? w_quot : w_prod[31:0];

endmodule
`default_nettype wire

// File: rtl/mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : mult_div_unit
// Description : E-stage HI/LO unit with emulated multicycle mult/div latency.
// Revision    : 1.0 - initial release
// ============================================================================
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [START_SIZE-1:0]  Start,
    input  logic [XALUOP_SIZE-1:0] XAluOp,
    input  logic [31:0]            A,
    input  logic [31:0]            B,
    input  logic                   Cancel,
    output logic                   Busy,
    output logic [31:0]            HI,
    output logic [31:0]            LO
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES) + 1;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;
    logic [31:0]      pend_hi_q, pend_hi_d;
    logic [31:0]      pend_lo_q, pend_lo_d;
    logic             pend_wr_q, pend_wr_d;

    logic [31:0]      w_res_hi;
    logic [31:0]      w_res_lo;
    logic             w_div_zero;
    logic             w_is_mult;

    md_arith u_arith (
        .A        (A),
        .B        (B),
        .XAluOp   (XAluOp),
        .res_hi   (w_res_hi),
        .res_lo   (w_res_lo),
        .div_zero (w_div_zero)
    );

    assign w_is_mult = (XAluOp == MD_MULT) || (XAluOp == MD_MULTU);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        pend_wr_d = pend_wr_q;
        case (state_q)
            ST_IDLE: begin
                if (!Cancel) begin
                    if (Start == MD_RUN && XAluOp[2] == 1'b0) begin
                        pend_hi_d = w_res_hi;
                        pend_lo_d = w_res_lo;
                        pend_wr_d = !w_div_zero;
                        cnt_d     = w_is_mult ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
                        state_d   = ST_RUN;
                    end else if (Start == MD_MOVE) begin
                        if (XAluOp == MD_MTHI) hi_d = A;
                        if (XAluOp == MD_MTLO) lo_d = A;
                    end
                end
            end
            default: begin
                // In flight: new Starts and Cancel are deliberately ignored.
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    if (pend_wr_q) begin
                        hi_d = pend_hi_q;
                        lo_d = pend_lo_q;
                    end
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
            pend_wr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_wr_q <= pend_wr_d;
        end
    end

    assign Busy = (state_q == ST_RUN);
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mult_div_unit
// Description : Directed and random checks of mult_div_unit against a reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mult_div_unit;

    localparam int C_MULT = 5;
    localparam int C_DIV  = 10;

    logic        clk;
    logic        rst_n;
    logic [1:0]  Start;
    logic [2:0]  XAluOp;
    logic [31:0] A;
    logic [31:0] B;
    logic        Cancel;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;

    mult_div_unit #(.MULT_CYCLES(C_MULT), .DIV_CYCLES(C_DIV)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .Start  (Start),
        .XAluOp (XAluOp),
        .A      (A),
        .B      (B),
        .Cancel (Cancel),
        .Busy   (Busy),
        .HI     (HI),
        .LO     (LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference state: architectural HI/LO plus the result waiting to commit.
    logic [31:0] m_hi, m_lo, m_phi, m_plo;
    int          m_left;
    bit          m_wr;
    int          m_hazards;
    int          dut_hazards;

    // Hazard monitor: a Start arriving while the unit is busy is a hazard-unit violation.
    always @(posedge clk) begin
        if (rst_n && Busy && Start != 2'd0) dut_hazards++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_hi = '0; m_lo = '0; m_phi = '0; m_plo = '0;
        m_left = 0; m_wr = 1'b0;
    endtask

    task automatic model_compute(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        m_wr = 1'b1;
        case (op)
            3'd0: p = 64'(sa * sb);
            3'd1: p = {32'd0, a} * {32'd0, b};
            3'd2: begin
                if (b == 0) begin m_wr = 1'b0; p = '0; end
                else begin q = sa / sb; r = sa % sb; p = {r[31:0], q[31:0]}; end
            end
            default: begin
                if (b == 0) begin m_wr = 1'b0; p = '0; end
                else p = {a % b, a / b};
            end
        endcase
        {m_phi, m_plo} = p;
        m_left = (op < 3'd2) ? C_MULT : C_DIV;
    endtask

    task automatic model_edge(input logic [1:0] st, input logic [2:0] op,
                              input logic [31:0] a, input logic [31:0] b, input logic can);
        if (m_left > 0) begin
            if (st != 2'd0) m_hazards++;
            m_left--;
            if (m_left == 0 && m_wr) begin m_hi = m_phi; m_lo = m_plo; end
        end else if (!can) begin
            if (st == 2'd1 && op < 3'd4) model_compute(op, a, b);
            else if (st == 2'd2 && op == 3'd4) m_hi = a;
            else if (st == 2'd2 && op == 3'd5) m_lo = a;
        end
    endtask

    // One clock: drive at negedge, advance the model at posedge, sample just after.
    task automatic apply(input logic [1:0] st, input logic [2:0] op,
                         input logic [31:0] a, input logic [31:0] b, input logic can);
        @(negedge clk);
        Start = st; XAluOp = op; A = a; B = b; Cancel = can;
        @(posedge clk);
        model_edge(st, op, a, b, can);
        #1;
        check("busy", {63'd0, Busy}, {63'd0, (m_left > 0)});
        check("hilo", {HI, LO}, {m_hi, m_lo});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) apply(2'd0, 3'd0, 32'd0, 32'd0, 1'b0);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'h0000_0001;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [1:0] st;
        int r;
        m_hazards = 0;
        dut_hazards = 0;
        model_reset();
        rst_n = 1'b0; Start = '0; XAluOp = '0; A = '0; B = '0; Cancel = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", {63'd0, Busy}, 64'd0);
        check("rst_hilo", {HI, LO}, 64'd0);
        @(negedge clk) rst_n = 1'b1;

        // Multiply: signed and unsigned with the same operands
        apply(2'd1, 3'd0, 32'hFFFF_FFFD, 32'd5, 1'b0);
        idle(C_MULT);
        check("mult_neg", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFF1);
        apply(2'd1, 3'd1, 32'hFFFF_FFFF, 32'd2, 1'b0);
        idle(C_MULT);
        check("multu", {HI, LO}, 64'h0000_0001_FFFF_FFFE);
        apply(2'd1, 3'd0, 32'hFFFF_FFFF, 32'd2, 1'b0);
        idle(C_MULT);
        check("mult_m1", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFFE);

        // Divide, divide-by-zero, signed overflow
        apply(2'd1, 3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
        idle(C_DIV);
        check("div_neg", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFFD);
        apply(2'd1, 3'd3, 32'd7, 32'd0, 1'b0);
        idle(C_DIV);
        check("divu_zero", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFFD);
        apply(2'd1, 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        idle(C_DIV);
        check("div_ovf", {HI, LO}, 64'h0000_0000_8000_0000);

        // Moves and cancels
        apply(2'd2, 3'd4, 32'h1234_5678, 32'd0, 1'b0);
        check("mthi", {32'd0, HI}, 64'h1234_5678);
        apply(2'd2, 3'd5, 32'hDEAD_BEEF, 32'd0, 1'b1);
        check("mtlo_cancel", {32'd0, LO}, 64'h8000_0000);
        apply(2'd1, 3'd0, 32'd3, 32'd3, 1'b1);
        check("mult_cancel", {63'd0, Busy}, 64'd0);
        apply(2'd3, 3'd4, 32'hAAAA_AAAA, 32'd1, 1'b0);
        apply(2'd2, 3'd6, 32'hAAAA_AAAA, 32'd1, 1'b0);

        // Hazard during RUN, then Cancel during RUN must not abort
        apply(2'd1, 3'd3, 32'd100, 32'd7, 1'b0);
        apply(2'd1, 3'd0, 32'd9, 32'd9, 1'b0);
        apply(2'd0, 3'd0, 32'd0, 32'd0, 1'b1);
        idle(C_DIV - 2);
        check("divu_commit", {HI, LO}, {32'd2, 32'd14});
        check("hazard_flag", 64'(dut_hazards), 64'd1);

        // Asynchronous reset mid-run at count==4
        apply(2'd1, 3'd2, 32'd50, 32'd3, 1'b0);
        idle(C_DIV - 4);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check("arst_busy", {63'd0, Busy}, 64'd0);
        check("arst_hilo", {HI, LO}, 64'd0);
        @(negedge clk) rst_n = 1'b1;
        idle(6);
        check("no_commit", {HI, LO}, 64'd0);
        apply(2'd1, 3'd0, 32'd6, 32'd7, 1'b0);
        idle(C_MULT);
        check("mult_6x7", {HI, LO}, 64'd42);

        // Random traffic, including hazards, cancels and reserved encodings
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 9);
            st = (r < 6) ? 2'd0 : (r < 8) ? 2'd1 : (r == 8) ? 2'd2 : 2'd3;
            apply(st, 3'($urandom_range(0, 7)), pick(), pick(), ($urandom_range(0, 7) == 0));
        end
        idle(C_DIV + 1);
        check("hazard_count", 64'(dut_hazards), 64'(m_hazards));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
